// File: rtl/wb_regfile.sv
// Write-back stage and register file: selects the write-back source, commits it to the register
// file, and counts committed writes. Define WB_REGFILE_BYPASS_EN for same-cycle read bypass.
module wb_regfile #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mem_to_reg_is,
  input  logic              reg_w_en_is,
  input  logic [2:0]        w_reg_is,
  input  logic [DATA_W-1:0] ALU_out_is,
  input  logic [DATA_W-1:0] mem_out_is,
  input  logic [2:0]        r1_sel,
  input  logic [2:0]        r2_sel,
  output logic [DATA_W-1:0] r1_data,
  output logic [DATA_W-1:0] r2_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_w_en,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [15:0]       wr_count_q;
  logic [DATA_W-1:0] r1_stored;
  logic [DATA_W-1:0] r2_stored;

  assign wb_data  = mem_to_reg_is ? mem_out_is : ALU_out_is;
  // Reset also gates the strobe so forwarding logic never sees a write that will be discarded.
  assign wb_w_en  = reg_w_en_is & en & ~rst;
  assign wr_count = wr_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wb_w_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_reg_is == 3'(i)) begin
          regs_q[i] <= wb_data;
        end
      end
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  always_comb begin
    r1_stored = '0;
    r2_stored = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r1_sel == 3'(i)) begin
        r1_stored = regs_q[i];
      end
      if (r2_sel == 3'(i)) begin
        r2_stored = regs_q[i];
      end
    end
  end

  always_comb begin
    r1_data = r1_stored;
    r2_data = r2_stored;
`ifdef WB_REGFILE_BYPASS_EN
    // Write-before-read: a reader of the register being written sees the new value now.
    if (wb_w_en && (r1_sel == w_reg_is)) begin
      r1_data = wb_data;
    end
    if (wb_w_en && (r2_sel == w_reg_is)) begin
      r2_data = wb_data;
    end
`else
    r1_data = r1_stored;
    r2_data = r2_stored;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, source select, stall, bypass, counter wrap.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mem_to_reg_is;
  logic        reg_w_en_is;
  logic [2:0]  w_reg_is;
  logic [15:0] ALU_out_is;
  logic [15:0] mem_out_is;
  logic [2:0]  r1_sel;
  logic [2:0]  r2_sel;
  logic [15:0] r1_data;
  logic [15:0] r2_data;
  logic [15:0] wb_data;
  logic        wb_w_en;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  wb_regfile #(
    .DATA_W  (16),
    .NUM_REGS(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mem_to_reg_is(mem_to_reg_is),
    .reg_w_en_is  (reg_w_en_is),
    .w_reg_is     (w_reg_is),
    .ALU_out_is   (ALU_out_is),
    .mem_out_is   (mem_out_is),
    .r1_sel       (r1_sel),
    .r2_sel       (r2_sel),
    .r1_data      (r1_data),
    .r2_data      (r2_data),
    .wb_data      (wb_data),
    .wb_w_en      (wb_w_en),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single qualified write; inputs change 1 time unit after the edge.
  task automatic do_write(input logic [2:0] sel, input logic [15:0] alu, input logic [15:0] mem,
                          input logic m2r);
    w_reg_is      = sel;
    ALU_out_is    = alu;
    mem_out_is    = mem;
    mem_to_reg_is = m2r;
    en            = 1'b1;
    reg_w_en_is   = 1'b1;
    @(posedge clk);
    #1;
    reg_w_en_is   = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b0;
    mem_to_reg_is = 1'b0;
    reg_w_en_is   = 1'b0;
    w_reg_is      = 3'd0;
    ALU_out_is    = 16'h0000;
    mem_out_is    = 16'h0000;
    r1_sel        = 3'd0;
    r2_sel        = 3'd1;
    #2;
    check("reset_r1", r1_data, 16'h0000);
    check("reset_r2", r2_data, 16'h0000);
    check("reset_count", wr_count, 16'h0000);
    check("reset_wb_w_en", {15'd0, wb_w_en}, 16'h0000);

    // Reset race: write request to R4 held across an edge while in reset.
    ALU_out_is    = 16'h1111;
    mem_out_is    = 16'h2222;
    mem_to_reg_is = 1'b1;
    en            = 1'b1;
    reg_w_en_is   = 1'b1;
    w_reg_is      = 3'd4;
    #1;
    check("reset_wb_data_mem", wb_data, 16'h2222);
    check("reset_wb_w_en_req", {15'd0, wb_w_en}, 16'h0000);
    mem_to_reg_is = 1'b0;
    ALU_out_is    = 16'h7777;
    #1;
    check("reset_wb_data_alu", wb_data, 16'h7777);
    @(posedge clk);
    #1;
    reg_w_en_is = 1'b0;
    rst         = 1'b0;
    r1_sel      = 3'd4;
    #1;
    check("race_r4", r1_data, 16'h0000);
    check("race_count", wr_count, 16'h0000);

    // First write after reset.
    w_reg_is    = 3'd3;
    ALU_out_is  = 16'h1234;
    reg_w_en_is = 1'b1;
    r1_sel      = 3'd3;
    #1;
    check("wb_w_en_active", {15'd0, wb_w_en}, 16'h0001);
    check("wb_data_alu", wb_data, 16'h1234);
    @(posedge clk);
    #1;
    reg_w_en_is = 1'b0;
    check("first_write_r3", r1_data, 16'h1234);
    check("first_write_count", wr_count, 16'h0001);

    // Source select into R5.
    r2_sel = 3'd5;
    do_write(3'd5, 16'hAAAA, 16'h5555, 1'b1);
    check("src_mem_r5", r2_data, 16'h5555);
    do_write(3'd5, 16'hAAAA, 16'h5555, 1'b0);
    check("src_alu_r5", r2_data, 16'hAAAA);
    check("src_count", wr_count, 16'h0003);

    // Register 0 is a real register.
    do_write(3'd0, 16'hC0DE, 16'h0000, 1'b0);
    r1_sel = 3'd0;
    #1;
    check("r0_writable", r1_data, 16'hC0DE);
    r1_sel = 3'd3;
    #1;
    check("indep_r1", r1_data, 16'h1234);
    check("indep_r2", r2_data, 16'hAAAA);

    // Stall: request present but stage not enabled.
    r1_sel      = 3'd2;
    en          = 1'b0;
    reg_w_en_is = 1'b1;
    w_reg_is    = 3'd2;
    ALU_out_is  = 16'hBEEF;
    #1;
    check("stall_wb_w_en", {15'd0, wb_w_en}, 16'h0000);
    @(posedge clk);
    #1;
    check("stall_r2", r1_data, 16'h0000);
    check("stall_count", wr_count, 16'h0004);
    // Enabled but no request.
    en          = 1'b1;
    reg_w_en_is = 1'b0;
    @(posedge clk);
    #1;
    check("noreq_r2", r1_data, 16'h0000);
    check("noreq_count", wr_count, 16'h0004);

    // Bypass behaviour on R7 (previously zero).
    r1_sel        = 3'd7;
    r2_sel        = 3'd7;
    w_reg_is      = 3'd7;
    ALU_out_is    = 16'h00FF;
    mem_to_reg_is = 1'b0;
    reg_w_en_is   = 1'b1;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("bypass_pre_r1", r1_data, 16'h00FF);
    check("bypass_pre_r2", r2_data, 16'h00FF);
`else
    check("bypass_pre_r1", r1_data, 16'h0000);
    check("bypass_pre_r2", r2_data, 16'h0000);
`endif
    @(posedge clk);
    #1;
    reg_w_en_is = 1'b0;
    check("bypass_post_r1", r1_data, 16'h00FF);
    check("bypass_post_r2", r2_data, 16'h00FF);
    check("bypass_count", wr_count, 16'h0005);

    // Mid-run asynchronous reset, no clock edge involved.
    r1_sel = 3'd3;
    #1;
    check("pre_reset_r3", r1_data, 16'h1234);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_r3", r1_data, 16'h0000);
    check("async_reset_r7", r2_data, 16'h0000);
    check("async_reset_count", wr_count, 16'h0000);
    #1;
    rst = 1'b0;

    // Counter wrap: 65535 writes then one more.
    r1_sel      = 3'd1;
    w_reg_is    = 3'd1;
    ALU_out_is  = 16'h0001;
    en          = 1'b1;
    reg_w_en_is = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap_ffff", wr_count, 16'hFFFF);
    @(posedge clk);
    #1;
    reg_w_en_is = 1'b0;
    check("wrap_zero", wr_count, 16'h0000);
    check("wrap_r1", r1_data, 16'h0001);
    @(posedge clk);
    #1;
    check("wrap_hold", wr_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
